// File: rtl/obi2axi_if.sv
// Bus bundle for the OBI-to-AXI4-Lite bridge: the OBI slave side and the
// AXI4-Lite master side. The "master" modport is the bridge's view (it masters AXI).
// The "slave" modport is the environment's view: the OBI core plus the AXI peripheral.
interface obi2axi_if #(
    parameter int AddrWidth = 32,
    parameter int DataWidth = 32
);
    // OBI side
    logic                   data_req_i;
    logic                   data_gnt_o;
    logic [AddrWidth-1:0]   data_addr_i;
    logic                   data_we_i;
    logic [3:0]             data_be_i;
    logic [DataWidth-1:0]   data_wdata_i;
    logic                   data_rvalid_o;
    logic [DataWidth-1:0]   data_rdata_o;
    logic                   data_err_o;

    // AXI4-Lite write address / data / response
    logic [AddrWidth-1:0]   m00_axi_awaddr;
    logic [2:0]             m00_axi_awprot;
    logic                   m00_axi_awvalid;
    logic                   m00_axi_awready;
    logic [DataWidth-1:0]   m00_axi_wdata;
    logic [3:0]             m00_axi_wstrb;
    logic                   m00_axi_wvalid;
    logic                   m00_axi_wready;
    logic [1:0]             m00_axi_bresp;
    logic                   m00_axi_bvalid;
    logic                   m00_axi_bready;

    // AXI4-Lite read address / data
    logic [AddrWidth-1:0]   m00_axi_araddr;
    logic [2:0]             m00_axi_arprot;
    logic                   m00_axi_arvalid;
    logic                   m00_axi_arready;
    logic [DataWidth-1:0]   m00_axi_rdata;
    logic [1:0]             m00_axi_rresp;
    logic                   m00_axi_rvalid;
    logic                   m00_axi_rready;

    modport master (
        input  data_req_i, data_addr_i, data_we_i, data_be_i, data_wdata_i,
        output data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o,
        output m00_axi_awaddr, m00_axi_awprot, m00_axi_awvalid,
        input  m00_axi_awready,
        output m00_axi_wdata, m00_axi_wstrb, m00_axi_wvalid,
        input  m00_axi_wready,
        input  m00_axi_bresp, m00_axi_bvalid,
        output m00_axi_bready,
        output m00_axi_araddr, m00_axi_arprot, m00_axi_arvalid,
        input  m00_axi_arready,
        input  m00_axi_rdata, m00_axi_rresp, m00_axi_rvalid,
        output m00_axi_rready
    );

    modport slave (
        output data_req_i, data_addr_i, data_we_i, data_be_i, data_wdata_i,
        input  data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o,
        input  m00_axi_awaddr, m00_axi_awprot, m00_axi_awvalid,
        output m00_axi_awready,
        input  m00_axi_wdata, m00_axi_wstrb, m00_axi_wvalid,
        output m00_axi_wready,
        output m00_axi_bresp, m00_axi_bvalid,
        input  m00_axi_bready,
        input  m00_axi_araddr, m00_axi_arprot, m00_axi_arvalid,
        output m00_axi_arready,
        output m00_axi_rdata, m00_axi_rresp, m00_axi_rvalid,
        input  m00_axi_rready
    );
endinterface

// File: rtl/obi2axi.sv
// OBI slave to AXI4-Lite master bridge. Each granted OBI request becomes exactly
// one AXI4-Lite read or write. Only one transaction is ever outstanding. The AXI
// response comes back to the core as a single-cycle OBI rvalid.
module obi2axi #(
    parameter int         AddrWidth = 32,
    parameter int         DataWidth = 32,   // bridge is word-only; must be 32
    parameter logic [2:0] AxProt    = 3'b000
) (
    input  logic        m00_axi_aclk,
    input  logic        m00_axi_aresetn,
    obi2axi_if.master   bus
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_WRITE   = 3'd1;
    localparam logic [2:0] S_WAIT_B  = 3'd2;
    localparam logic [2:0] S_READ_AR = 3'd3;
    localparam logic [2:0] S_WAIT_R  = 3'd4;
    localparam logic [2:0] S_RESP    = 3'd5;

    logic [2:0]           r_state;
    logic [AddrWidth-1:0] r_addr;
    logic [DataWidth-1:0] r_wdata;
    logic [3:0]           r_wstrb;
    logic                 r_awvalid;
    logic                 r_wvalid;
    logic                 r_arvalid;
    logic                 r_aw_done;
    logic                 r_w_done;
    logic [DataWidth-1:0] r_rdata;
    logic                 r_err;

    logic                 w_grant;
    logic                 w_aw_hs;
    logic                 w_w_hs;
    logic                 w_aw_all;
    logic                 w_w_all;

    // The grant is gated by reset so that it drops immediately when reset is asserted.
    assign w_grant  = bus.data_req_i && (r_state == S_IDLE) && m00_axi_aresetn;
    assign w_aw_hs  = r_awvalid && bus.m00_axi_awready;
    assign w_w_hs   = r_wvalid  && bus.m00_axi_wready;
    // A channel counts as finished if it completed earlier or completes this cycle.
    assign w_aw_all = r_aw_done || w_aw_hs;
    assign w_w_all  = r_w_done  || w_w_hs;

    // OBI outputs
    assign bus.data_gnt_o    = w_grant;
    assign bus.data_rvalid_o = (r_state == S_RESP);
    assign bus.data_rdata_o  = r_rdata;
    assign bus.data_err_o    = r_err;

    // AXI outputs. The address, data and strobe registers change only on a grant,
    // so they stay stable while any valid is high.
    assign bus.m00_axi_awaddr  = r_addr;
    assign bus.m00_axi_awprot  = AxProt;
    assign bus.m00_axi_awvalid = r_awvalid;
    assign bus.m00_axi_wdata   = r_wdata;
    assign bus.m00_axi_wstrb   = r_wstrb;
    assign bus.m00_axi_wvalid  = r_wvalid;
    assign bus.m00_axi_bready  = (r_state == S_WAIT_B);
    assign bus.m00_axi_araddr  = r_addr;
    assign bus.m00_axi_arprot  = AxProt;
    assign bus.m00_axi_arvalid = r_arvalid;
    assign bus.m00_axi_rready  = (r_state == S_WAIT_R);

    // Transaction FSM: capture on grant, run the AXI channels, and return one OBI response.
    always_ff @(posedge m00_axi_aclk or negedge m00_axi_aresetn) begin
        if (!m00_axi_aresetn) begin
            r_state   <= S_IDLE;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_arvalid <= 1'b0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_rdata   <= '0;
            r_err     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant) begin
                        r_addr  <= bus.data_addr_i;
                        r_wdata <= bus.data_wdata_i;
                        r_wstrb <= bus.data_be_i;
                        if (bus.data_we_i) begin
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                            r_state   <= S_WRITE;
                        end else begin
                            r_arvalid <= 1'b1;
                            r_state   <= S_READ_AR;
                        end
                    end
                end
                S_WRITE: begin
                    // AW and W retire independently and may complete in either order.
                    if (w_aw_hs) begin
                        r_awvalid <= 1'b0;
                        r_aw_done <= 1'b1;
                    end
                    if (w_w_hs) begin
                        r_wvalid <= 1'b0;
                        r_w_done <= 1'b1;
                    end
                    if (w_aw_all && w_w_all) begin
                        r_aw_done <= 1'b0;
                        r_w_done  <= 1'b0;
                        r_state   <= S_WAIT_B;
                    end
                end
                S_WAIT_B: begin
                    if (bus.m00_axi_bvalid) begin
                        r_err   <= (bus.m00_axi_bresp != 2'b00);
                        r_rdata <= '0;
                        r_state <= S_RESP;
                    end
                end
                S_READ_AR: begin
                    if (bus.m00_axi_arready) begin
                        r_arvalid <= 1'b0;
                        r_state   <= S_WAIT_R;
                    end
                end
                S_WAIT_R: begin
                    // Read data is forwarded even on an error response.
                    if (bus.m00_axi_rvalid) begin
                        r_rdata <= bus.m00_axi_rdata;
                        r_err   <= (bus.m00_axi_rresp != 2'b00);
                        r_state <= S_RESP;
                    end
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_obi2axi.sv
// Self-checking bench for obi2axi. A table of single transactions is driven
// against a cycle-accurate AXI slave model. Hand-written sequences then cover
// reset, back-to-back requests and reset in the middle of a write.
module tb_obi2axi;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    obi2axi_if #(.AddrWidth(32), .DataWidth(32)) bus ();

    obi2axi #(.AddrWidth(32), .DataWidth(32), .AxProt(3'b000)) dut (
        .m00_axi_aclk    (clk),
        .m00_axi_aresetn (rst_n),
        .bus             (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          ax_cyc;     // first cycle awready/arready is high
        int          w_cyc;      // first cycle wready is high
        int          resp_lat;   // cycles from last address/data handshake to B/R valid
        logic [1:0]  resp;
        logic [31:0] slv_rdata;
        int          exp_rv_cyc;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic slave_idle();
        bus.m00_axi_awready = 1'b0;
        bus.m00_axi_wready  = 1'b0;
        bus.m00_axi_bvalid  = 1'b0;
        bus.m00_axi_bresp   = 2'b00;
        bus.m00_axi_arready = 1'b0;
        bus.m00_axi_rvalid  = 1'b0;
        bus.m00_axi_rresp   = 2'b00;
        bus.m00_axi_rdata   = 32'h0;
    endtask

    // Runs one OBI transaction; cycle 0 is the cycle in which the grant is expected.
    task automatic run_vec(input vec_t v);
        int          aw_hs;
        int          w_hs;
        int          ar_hs;
        int          hs_done;
        int          rv_cyc;
        int          bad_payload;
        int          bad_proto;
        logic        resp_done;
        logic [31:0] got_rdata;
        logic        got_err;
        aw_hs = 0; w_hs = 0; ar_hs = 0; hs_done = -1; rv_cyc = -1;
        bad_payload = 0; bad_proto = 0; resp_done = 1'b0;
        got_rdata = 32'h0; got_err = 1'b0;

        @(negedge clk);
        slave_idle();
        bus.data_req_i   = 1'b1;
        bus.data_we_i    = v.we;
        bus.data_addr_i  = v.addr;
        bus.data_wdata_i = v.wdata;
        bus.data_be_i    = v.be;
        #1;
        check({v.name, "_gnt_c0"}, {63'd0, bus.data_gnt_o}, 64'd1);

        for (int cyc = 1; cyc < 60 && rv_cyc < 0; cyc++) begin
            @(negedge clk);
            bus.data_req_i      = 1'b0;
            bus.data_wdata_i    = 32'h0;
            bus.data_be_i       = 4'h0;
            bus.m00_axi_awready = v.we && (cyc >= v.ax_cyc);
            bus.m00_axi_wready  = v.we && (cyc >= v.w_cyc);
            bus.m00_axi_arready = !v.we && (cyc >= v.ax_cyc);
            bus.m00_axi_bvalid  = v.we && !resp_done && (hs_done >= 0) && (cyc >= hs_done + v.resp_lat);
            bus.m00_axi_bresp   = v.resp;
            bus.m00_axi_rvalid  = !v.we && !resp_done && (hs_done >= 0) && (cyc >= hs_done + v.resp_lat);
            bus.m00_axi_rresp   = v.resp;
            bus.m00_axi_rdata   = v.slv_rdata;
            #1;
            if (bus.m00_axi_awvalid && (bus.m00_axi_awaddr !== v.addr || bus.m00_axi_awprot !== 3'b000)) bad_payload++;
            if (bus.m00_axi_wvalid && (bus.m00_axi_wdata !== v.wdata || bus.m00_axi_wstrb !== v.be)) bad_payload++;
            if (bus.m00_axi_arvalid && (bus.m00_axi_araddr !== v.addr || bus.m00_axi_arprot !== 3'b000)) bad_payload++;
            if (bus.m00_axi_bready && !(v.we && aw_hs == 1 && w_hs == 1)) bad_proto++;
            if (bus.m00_axi_rready && !(!v.we && ar_hs == 1)) bad_proto++;
            if (v.we && bus.m00_axi_arvalid) bad_proto++;
            if (!v.we && (bus.m00_axi_awvalid || bus.m00_axi_wvalid)) bad_proto++;
            if (bus.data_gnt_o) bad_proto++;
            if (bus.data_rvalid_o) begin
                rv_cyc    = cyc;
                got_rdata = bus.data_rdata_o;
                got_err   = bus.data_err_o;
            end
            if (bus.m00_axi_awvalid && bus.m00_axi_awready) aw_hs++;
            if (bus.m00_axi_wvalid && bus.m00_axi_wready) w_hs++;
            if (bus.m00_axi_arvalid && bus.m00_axi_arready) ar_hs++;
            if ((bus.m00_axi_bvalid && bus.m00_axi_bready) || (bus.m00_axi_rvalid && bus.m00_axi_rready))
                resp_done = 1'b1;
            if (hs_done < 0 && (v.we ? (aw_hs >= 1 && w_hs >= 1) : (ar_hs >= 1))) hs_done = cyc;
        end

        @(negedge clk);
        slave_idle();
        #1;
        check({v.name, "_rvalid_cycle"}, 64'(rv_cyc), 64'(v.exp_rv_cyc));
        check({v.name, "_rdata"}, {32'd0, got_rdata}, {32'd0, v.exp_rdata});
        check({v.name, "_err"}, {63'd0, got_err}, {63'd0, v.exp_err});
        check({v.name, "_aw_hs"}, 64'(aw_hs), v.we ? 64'd1 : 64'd0);
        check({v.name, "_w_hs"}, 64'(w_hs), v.we ? 64'd1 : 64'd0);
        check({v.name, "_ar_hs"}, 64'(ar_hs), v.we ? 64'd0 : 64'd1);
        check({v.name, "_payload_bad"}, 64'(bad_payload), 64'd0);
        check({v.name, "_protocol_bad"}, 64'(bad_proto), 64'd0);
        check({v.name, "_single_rvalid"}, {63'd0, bus.data_rvalid_o}, 64'd0);
        $display("txn %s: we=%0b addr=%h rvalid@%0d rdata=%h err=%0b", v.name, v.we, v.addr, rv_cyc, got_rdata, got_err);
    endtask

    // Three reads with the request held high; the slave answers R five cycles after AR.
    task automatic back_to_back();
        logic [31:0] addrs[3];
        logic [31:0] vals[3];
        int          gnt_cyc[3];
        int          rv_cyc[3];
        logic [31:0] rv_data[3];
        int          n_gnt;
        int          n_rv;
        int          ar_idx;
        int          ar_hs_cyc;
        logic        pending;
        int          bad;
        addrs[0] = 32'h5000_0000; addrs[1] = 32'h5000_0004; addrs[2] = 32'h5000_0008;
        vals[0]  = 32'h1111_0001; vals[1]  = 32'h2222_0002; vals[2]  = 32'h3333_0003;
        for (int i = 0; i < 3; i++) begin gnt_cyc[i] = -1; rv_cyc[i] = -1; rv_data[i] = 32'h0; end
        n_gnt = 0; n_rv = 0; ar_idx = 0; ar_hs_cyc = 0; pending = 1'b0; bad = 0;

        for (int cyc = 0; cyc < 40 && n_rv < 3; cyc++) begin
            @(negedge clk);
            bus.data_req_i      = (n_gnt < 3);
            bus.data_we_i       = 1'b0;
            bus.data_addr_i     = (n_gnt < 3) ? addrs[n_gnt] : 32'h0;
            bus.m00_axi_arready = 1'b1;
            bus.m00_axi_rvalid  = pending && (cyc >= ar_hs_cyc + 5);
            bus.m00_axi_rresp   = 2'b00;
            bus.m00_axi_rdata   = vals[ar_idx];
            #1;
            if (bus.m00_axi_arvalid && pending) bad++;
            if (bus.m00_axi_arvalid && bus.m00_axi_araddr !== addrs[ar_idx]) bad++;
            if (bus.data_gnt_o && n_gnt < 3) begin gnt_cyc[n_gnt] = cyc; n_gnt++; end
            if (bus.data_rvalid_o && n_rv < 3) begin rv_cyc[n_rv] = cyc; rv_data[n_rv] = bus.data_rdata_o; n_rv++; end
            if (bus.m00_axi_arvalid && bus.m00_axi_arready) begin pending = 1'b1; ar_hs_cyc = cyc; end
            if (bus.m00_axi_rvalid && bus.m00_axi_rready) begin pending = 1'b0; ar_idx = (ar_idx < 2) ? ar_idx + 1 : 2; end
        end
        @(negedge clk);
        bus.data_req_i = 1'b0;
        slave_idle();
        for (int i = 0; i < 3; i++) begin
            check($sformatf("b2b_gnt_cycle%0d", i), 64'(gnt_cyc[i]), 64'(8 * i));
            check($sformatf("b2b_rvalid_cycle%0d", i), 64'(rv_cyc[i]), 64'(8 * i + 7));
            check($sformatf("b2b_rdata%0d", i), {32'd0, rv_data[i]}, {32'd0, vals[i]});
        end
        check("b2b_ar_overlap_or_addr", 64'(bad), 64'd0);
        $display("txn b2b: grants at %0d/%0d/%0d rvalids at %0d/%0d/%0d", gnt_cyc[0], gnt_cyc[1], gnt_cyc[2], rv_cyc[0], rv_cyc[1], rv_cyc[2]);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        vecs[0] = '{"rd_ok",       1'b0, 32'h1000_0040, 32'h0,         4'hF,    1, 0, 1, 2'b00, 32'hDEAD_BEEF, 3, 32'hDEAD_BEEF, 1'b0};
        vecs[1] = '{"wr_aw_first", 1'b1, 32'h2000_0008, 32'hA5A5_1234, 4'b0011, 1, 4, 1, 2'b00, 32'h0,         6, 32'h0,         1'b0};
        vecs[2] = '{"wr_w_first",  1'b1, 32'h2000_000C, 32'h0BAD_F00D, 4'b1100, 3, 1, 1, 2'b00, 32'h0,         5, 32'h0,         1'b0};
        vecs[3] = '{"wr_simul",    1'b1, 32'h2000_0010, 32'h1234_5678, 4'b1111, 1, 1, 1, 2'b00, 32'h0,         3, 32'h0,         1'b0};
        vecs[4] = '{"rd_slverr",   1'b0, 32'h3000_0000, 32'h0,         4'hF,    1, 0, 1, 2'b10, 32'h0000_0011, 3, 32'h0000_0011, 1'b1};
        vecs[5] = '{"wr_decerr",   1'b1, 32'h3000_0004, 32'hFFFF_0000, 4'b0101, 1, 1, 1, 2'b11, 32'h0,         3, 32'h0,         1'b1};
        vecs[6] = '{"rd_slow",     1'b0, 32'h4000_0100, 32'h0,         4'hF,    3, 0, 4, 2'b00, 32'hCAFE_0001, 8, 32'hCAFE_0001, 1'b0};
        vecs[7] = '{"wr_slow_b",   1'b1, 32'h4000_0200, 32'h5555_AAAA, 4'b1000, 2, 2, 3, 2'b00, 32'h0,         6, 32'h0,         1'b0};

        // Reset state: a pending request must not be granted while reset is held.
        rst_n            = 1'b0;
        bus.data_req_i   = 1'b1;
        bus.data_we_i    = 1'b0;
        bus.data_addr_i  = 32'h0;
        bus.data_be_i    = 4'h0;
        bus.data_wdata_i = 32'h0;
        slave_idle();
        repeat (3) @(negedge clk);
        #1;
        check("rst_gnt", {63'd0, bus.data_gnt_o}, 64'd0);
        check("rst_valids", {60'd0, bus.m00_axi_awvalid, bus.m00_axi_wvalid, bus.m00_axi_arvalid, bus.data_rvalid_o}, 64'd0);
        check("rst_readys", {62'd0, bus.m00_axi_bready, bus.m00_axi_rready}, 64'd0);
        check("rst_rdata_err", {31'd0, bus.data_err_o, bus.data_rdata_o}, 64'd0);
        @(negedge clk);
        bus.data_req_i = 1'b0;
        rst_n          = 1'b1;

        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        back_to_back();

        // Reset while awvalid is high: valids and grant must drop without a clock edge.
        @(negedge clk);
        bus.data_req_i   = 1'b1;
        bus.data_we_i    = 1'b1;
        bus.data_addr_i  = 32'h6000_0000;
        bus.data_wdata_i = 32'h7777_7777;
        bus.data_be_i    = 4'hF;
        #1;
        check("rstmid_gnt", {63'd0, bus.data_gnt_o}, 64'd1);
        @(negedge clk);
        #1;
        check("rstmid_awvalid_before", {62'd0, bus.m00_axi_awvalid, bus.m00_axi_wvalid}, 64'd3);
        rst_n = 1'b0;
        #1;
        check("rstmid_valids_async", {61'd0, bus.m00_axi_awvalid, bus.m00_axi_wvalid, bus.m00_axi_arvalid}, 64'd0);
        check("rstmid_gnt_async", {63'd0, bus.data_gnt_o}, 64'd0);
        @(negedge clk);
        bus.data_req_i = 1'b0;
        rst_n          = 1'b1;
        #1;
        check("rstmid_idle_after", {62'd0, bus.m00_axi_awvalid, bus.m00_axi_bready}, 64'd0);
        $display("txn rst_mid_write: reset applied with awvalid high");
        run_vec(vecs[0]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/obi2axi.md
Name: obi2axi

Overview:
- OBI slave to AXI4-Lite master bridge. It is the reverse direction of the existing AXI-to-OBI path.
- It accepts single-word OBI requests from a core-v-mini-mcu bus master and issues them as AXI4-Lite read or write transactions toward an external AXI slave, such as an FPGA-side peripheral.
- One transaction is outstanding at a time. The AXI response is returned as a one-cycle OBI rvalid.

Parameters:
- AddrWidth, 32, OBI/AXI address width
- DataWidth, 32, OBI/AXI data width; must be 32
- AxProt, 3'b000, constant value driven on awprot/arprot

Ports:
- m00_axi_aclk  in  1  clock
- m00_axi_aresetn  in  1  reset; asynchronous, active-low
- data_req_i  in  1  OBI request
- data_gnt_o  out  1  OBI grant
- data_addr_i  in  AddrWidth  OBI address
- data_we_i  in  1  1 = write
- data_be_i  in  4  byte enables
- data_wdata_i  in  DataWidth  write data
- data_rvalid_o  out  1  OBI response valid
- data_rdata_o  out  DataWidth  read data; 0 for writes
- data_err_o  out  1  AXI resp != OKAY, valid with rvalid
- m00_axi_awaddr/awprot/awvalid  out  AddrWidth/3/1  write address channel
- m00_axi_awready  in  1
- m00_axi_wdata/wstrb/wvalid  out  DataWidth/DataWidth/8/1  write data channel
- m00_axi_wready  in  1
- m00_axi_bresp  in  2  write response
- m00_axi_bvalid  in  1
- m00_axi_bready  out  1
- m00_axi_araddr/arprot/arvalid  out  AddrWidth/3/1  read address channel
- m00_axi_arready  in  1
- m00_axi_rdata  in  DataWidth  read data
- m00_axi_rresp  in  2  read response
- m00_axi_rvalid  in  1
- m00_axi_rready  out  1

Behaviour:
- Clocking and reset: one clock, m00_axi_aclk. Reset m00_axi_aresetn is asynchronous, active-low.
- Reset values:
  - state = IDLE.
  - All valids/readys, data_gnt_o, data_rvalid_o and data_err_o = 0.
  - Address, data, strobe and response registers = 0.
- Grant: data_gnt_o = data_req_i when state == IDLE (combinational). It is 0 in all other states.
- Capture on grant: addr, wdata, be and we are latched.
  - we=1 → WRITE.
  - we=0 → READ_AR.
- Output registering: AXI payload and valid outputs come from registers. Payloads are held stable while the corresponding valid is high.
- WRITE state:
  - awvalid and wvalid both rise in the first cycle.
  - Flags aw_done/w_done are set on awvalid&awready and wvalid&wready respectively. Each valid drops the cycle after its own handshake, independently of the other; either channel order or a simultaneous handshake is legal.
  - When both flags are set → WAIT_B, and the flags are cleared.
  - wstrb = captured be; awaddr = captured addr.
- WAIT_B state:
  - bready = 1.
  - On bvalid: latch err = (bresp != 2'b00) and rdata = 0 → RESP.
- READ_AR state: arvalid = 1 until arready → WAIT_R.
- WAIT_R state:
  - rready = 1.
  - On rvalid: latch rdata and err = (rresp != 2'b00) → RESP.
- RESP state:
  - data_rvalid_o = 1 for exactly one cycle, with data_rdata_o/data_err_o valid.
  - Then → IDLE.
  - data_rdata_o holds its last value otherwise; it is only defined during rvalid.
- Latency, all-ready AXI slave:
  - Grant at cycle 0.
  - ar/aw valid at cycle 1, handshake at cycle 1.
  - R/B handshake at cycle 2 at the earliest.
  - data_rvalid_o at cycle 3.
- Back-to-back: a request held during a non-IDLE state is not granted. It is granted in the first IDLE cycle, which is the cycle after RESP.
- Protocol rules:
  - Never more than one AXI transaction outstanding.
  - bready is not asserted outside WAIT_B; rready is not asserted outside WAIT_R.
  - Stray bvalid/rvalid in other states are ignored.
- OBI error path: SLVERR/DECERR is reported via data_err_o=1. rdata is still forwarded for reads.
- Reset mid-transaction: immediate return to IDLE with all valids low. The in-flight AXI transaction is abandoned, which is acceptable only on a system-wide reset.

Test Plan:
- Read, all-ready slave: req, we=0, addr=0x1000_0040; slave returns rdata=0xDEADBEEF, OKAY → gnt cycle 0, araddr=0x1000_0040 at cycle 1, data_rvalid_o at cycle 3 with rdata=0xDEADBEEF, err=0.
- Write, AW before W: wdata=0xA5A5_1234, be=4'b0011; awready at cycle 1, wready at cycle 4 → awvalid drops cycle 2; wstrb=0011 held until cycle 4; bready only after both handshakes; rvalid one cycle after bvalid, rdata=0.
- Write, W before AW, then simultaneous: wready at cycle 1, awready at cycle 3; repeat with both at cycle 1 → exactly one AW and one W handshake each; B accepted; rvalid once per write.
- Error: read with rresp=2'b10, rdata=0x0000_0011 → data_err_o=1, data_rdata_o=0x11; write with bresp=2'b11 → data_err_o=1.
- Back-to-back: req held high over 3 reads with slave R latency 5 → gnt asserted only in IDLE cycles; no second arvalid before the first R handshake; three rvalids in order.
- Reset mid-write: assert m00_axi_aresetn=0 while awvalid=1 → all valids and gnt 0 asynchronously; after release, state IDLE and the next read completes normally.
